// File: rtl/mysystem_pio_input.sv
`default_nettype none
// ============================================================================
// Module  : mysystem_pio_input
// Brief   : Avalon-MM input PIO with sync, debounce, edge capture and IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module mysystem_pio_input #(
    parameter int WIDTH     = 8,
    parameter int DEBOUNCE  = 4,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [15:0] c_cnt_last  = 16'(DEBOUNCE - 1);
    localparam logic [1:0]  c_addr_data = 2'd0;
    localparam logic [1:0]  c_addr_dir  = 2'd1;
    localparam logic [1:0]  c_addr_mask = 2'd2;
    localparam logic [1:0]  c_addr_edge = 2'd3;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] w_update;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clear;
    logic             w_write;
    logic [31:0]      w_rdmux;
    logic             w_unused;

    assign w_write  = chipselect && !write_n;
    assign w_unused = ^writedata;
    assign w_clear  = (w_write && address == c_addr_edge) ? writedata[WIDTH-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [15:0] r_cnt;

            assign w_update[gi] = (r_s2[gi] != r_deb[gi]) && (r_cnt == c_cnt_last);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                end else if (r_s2[gi] == r_deb[gi] || w_update[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end

        // An update always moves deb to s2, so s2 is the new debounced level.
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_set = w_update & r_s2;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_set = w_update & ~r_s2;
        end else begin : g_any
            assign w_set = w_update;
        end
    endgenerate

    always_comb begin
        w_rdmux = '0;
        case (address)
            c_addr_data: w_rdmux[WIDTH-1:0] = r_deb;
            c_addr_dir:  w_rdmux = '0;
            c_addr_mask: w_rdmux[WIDTH-1:0] = r_irqmask;
            c_addr_edge: w_rdmux[WIDTH-1:0] = r_edgecap;
            default:     w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_deb     <= '0;
            r_irqmask <= '0;
            r_edgecap <= '0;
            readdata  <= '0;
        end else begin
            r_s1  <= in_port;
            r_s2  <= r_s1;
            r_deb <= r_deb ^ w_update;
            if (w_write && address == c_addr_mask) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            // Set is OR-ed after the clear so a coincident set survives.
            r_edgecap <= (r_edgecap & ~w_clear) | w_set;
            readdata  <= w_rdmux;
        end
    end

    assign irq = |(r_edgecap & r_irqmask);

endmodule
`default_nettype wire

// File: tb/tb_mysystem_pio_input.sv
`default_nettype none
// ============================================================================
// Module  : tb_mysystem_pio_input
// Brief   : Bench for mysystem_pio_input, one instance per edge type.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mysystem_pio_input;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [W-1:0] in_port = '0;
    logic [31:0] rd [3];
    logic [2:0]  irq_v;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mysystem_pio_input #(.WIDTH(W), .DEBOUNCE(DEB), .EDGE_TYPE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_v[0]));
    mysystem_pio_input #(.WIDTH(W), .DEBOUNCE(DEB), .EDGE_TYPE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_v[1]));
    mysystem_pio_input #(.WIDTH(W), .DEBOUNCE(DEB), .EDGE_TYPE(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_v[2]));

    // Reference model: the debounced value flips when the last DEB synchronized
    // samples all disagree with it; synchronized sample = input two edges ago.
    logic [W-1:0]  m_hist [2];
    logic [W-1:0]  m_win [$];
    logic [W-1:0]  m_deb, m_mask, m_upd, m_new, m_clr, m_set;
    logic [W-1:0]  m_ecap [3];
    logic [31:0]   m_rd [3];
    logic          m_irq;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_hist[0] = '0;
            m_hist[1] = '0;
            m_win     = {};
            for (int k = 0; k < DEB; k++) m_win.push_back('0);
            m_deb  = '0;
            m_mask = '0;
            for (int e = 0; e < 3; e++) begin
                m_ecap[e] = '0;
                m_rd[e]   = '0;
            end
        end else begin
            for (int e = 0; e < 3; e++) begin
                case (address)
                    2'd0:    m_rd[e] = 32'(m_deb);
                    2'd2:    m_rd[e] = 32'(m_mask);
                    2'd3:    m_rd[e] = 32'(m_ecap[e]);
                    default: m_rd[e] = 32'd0;
                endcase
            end
            m_win.push_back(m_hist[1]);
            void'(m_win.pop_front());
            m_upd = '1;
            foreach (m_win[k]) m_upd &= (m_win[k] ^ m_deb);
            m_new = m_deb ^ m_upd;
            m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int e = 0; e < 3; e++) begin
                m_set = (e == 0) ? (m_upd & m_new) : (e == 1) ? (m_upd & ~m_new) : m_upd;
                m_ecap[e] = (m_ecap[e] & ~m_clr) | m_set;
            end
            if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
            m_deb     = m_new;
            m_hist[1] = m_hist[0];
            m_hist[0] = in_port;
        end
        #1;
        for (int e = 0; e < 3; e++) begin
            m_irq = |(m_ecap[e] & m_mask);
            n_cmp++;
            if (rd[e] !== m_rd[e]) begin
                n_err++;
                $display("FAIL model_readdata inst%0d @%0t: got %h want %h", e, $time, rd[e], m_rd[e]);
            end
            n_cmp++;
            if (irq_v[e] !== m_irq) begin
                n_err++;
                $display("FAIL model_irq inst%0d @%0t: got %b want %b", e, $time, irq_v[e], m_irq);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        int hold;
        tick(3);
        reset_n = 1'b1;
        tick(10);
        check("idle_data", rd[0], 32'h0);
        check("idle_irq", 32'(irq_v), 32'h0);

        // Read latency of DATA
        in_port = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("latency_before", rd[0], 32'h0);
        end
        @(negedge clk);
        check("latency_hit", rd[0], 32'h5);
        address = 2'd3;
        @(negedge clk);
        check("rise_cap_t0", rd[0], 32'h5);
        check("rise_cap_t1", rd[1], 32'h0);
        check("rise_cap_t2", rd[2], 32'h5);
        in_port = 8'h00;
        tick(8);
        check("fall_cap_t1", rd[1], 32'h5);
        check("fall_cap_t2", rd[2], 32'h5);
        wr(2'd3, 32'hFF);
        @(negedge clk);
        check("w1c_all", rd[2], 32'h0);

        // Debounce: short glitch rejected, DEB-cycle pulse accepted
        wr(2'd2, 32'hFF);
        address = 2'd0;
        in_port = 8'h01;
        tick(3);
        in_port = 8'h00;
        tick(10);
        check("glitch_data", rd[0], 32'h0);
        check("glitch_irq", 32'(irq_v), 32'h0);
        in_port = 8'h01;
        tick(4);
        in_port = 8'h00;
        address = 2'd3;
        tick(10);
        check("pulse_cap_t0", rd[0], 32'h1);
        check("pulse_cap_t1", rd[1], 32'h1);
        check("pulse_irq", 32'(irq_v), 32'h7);

        // IRQ mask and write-1-to-clear
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h02);
        in_port = 8'h0A;
        tick(8);
        check("mask_irq_on", 32'(irq_v[0]), 32'h1);
        wr(2'd3, 32'h2);
        check("w1c_irq_off", 32'(irq_v[0]), 32'h0);
        @(negedge clk);
        check("w1c_remain", rd[0], 32'h8);
        wr(2'd2, 32'h08);
        check("remask_irq", 32'(irq_v[0]), 32'h1);

        // Set and clear of bit 4 on the same edge
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h10);
        in_port = 8'h1A;
        tick(5);
        wr(2'd3, 32'h10);
        check("set_wins_irq", 32'(irq_v), 32'h5);
        @(negedge clk);
        check("set_wins_cap", rd[0], 32'h10);

        // Asynchronous reset mid-operation with inputs held high
        wr(2'd2, 32'hFF);
        in_port = 8'hFF;
        address = 2'd0;
        tick(8);
        #2 reset_n = 1'b0;
        #1;
        for (int e = 0; e < 3; e++) check("async_rst_rd", rd[e], 32'h0);
        check("async_rst_irq", 32'(irq_v), 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("post_rst_before", rd[0], 32'h0);
        @(negedge clk);
        check("post_rst_data", rd[0], 32'hFF);
        address = 2'd3;
        @(negedge clk);
        check("post_rst_cap_t0", rd[0], 32'hFF);
        check("post_rst_cap_t1", rd[1], 32'h0);
        check("post_rst_cap_t2", rd[2], 32'hFF);

        // Randomized traffic, checked by the model every cycle
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                case ($urandom_range(0, 2))
                    0:       in_port = W'($urandom);
                    1:       in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
                    default: in_port = in_port;
                endcase
                hold = $urandom_range(1, 7);
            end else begin
                hold--;
            end
            chipselect = ($urandom_range(0, 4) == 0);
            write_n    = ($urandom_range(0, 1) == 1);
            address    = 2'($urandom);
            writedata  = $urandom;
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mysystem_pio_input.md
# mysystem_pio_input

Avalon-MM slave input PIO: samples an external `WIDTH`-bit input bus, synchronizes and debounces it, and latches configured edges into a sticky edge-capture register with a maskable level interrupt. It sits on the system interconnect beside the output PIOs and is the read side of the same register-mapped GPIO scheme, giving the CPU polled and interrupt-driven access to external signals.

## Interface
- `WIDTH`, 8: number of input bits, 1..32; register bits above `WIDTH-1` read as 0.
- `DEBOUNCE`, 4: number of consecutive mismatching cycles required before the debounced value changes, 1..65535.
- `EDGE_TYPE`, 0: edge that sets a capture bit; 0 = rising, 1 = falling, 2 = any.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: reset, asynchronous and active-low; clears all state.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, qualified by `chipselect`.
- `writedata` in 32: write data.
- `in_port` in `WIDTH`: external asynchronous inputs.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt, active-high.

## Operation
- Register map:
  - Address 0 DATA: read-only debounced input value. Writes are ignored.
  - Address 1 DIRECTION: reads 0. Writes are ignored.
  - Address 2 IRQMASK: read/write, `WIDTH` bits.
  - Address 3 EDGECAPTURE: read. A write clears every bit whose `writedata` bit is 1 (write-1-to-clear).
- Write: the write takes effect on the `clk` edge where `chipselect && !write_n`.
- Synchronizer, per bit: two flops `s1 <= in_port`, `s2 <= s1`.
- Debounce, per bit: a 16-bit counter `cnt` and a debounced value `deb`.
  - If `s2 == deb`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: `deb <= s2` and `cnt <= 0`; this is the update event.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE` cycles at `s2` never changes `deb`.
- Edge capture: on a bit's update event, the capture bit is set if the new `deb` matches `EDGE_TYPE`: 1 for rising, 0 for falling, either for any.
- Set and clear on the same edge for the same bit: set wins.
- Capture bits are sticky until cleared by a write.
- `irq = |(edgecapture & irqmask)`. It is combinational from registers and has no extra latency.
- Reset values are 0 for `s1`, `s2`, `deb`, `cnt`, IRQMASK, EDGECAPTURE, `readdata` and `irq`.
  - Because `deb` resets to 0, an input held high through reset release produces a rising-edge capture once synchronization and debounce complete. Software clears it at init.
- Reset asserted mid-debounce or mid-access: all state clears immediately; no partial update survives.

## Timing
- `readdata` is registered every cycle from the mux selected by `address`, regardless of `chipselect`. Read latency is 1: value for the `address` at edge N appears after edge N.
- A read of EDGECAPTURE on the same edge as a set or clear returns the pre-edge value.
- `in_port` change sampled at edge E0 gives:
  - `s1` at E0;
  - `s2` at E0+1;
  - `deb` and capture bit at E0+1+`DEBOUNCE`;
  - `irq` high the same cycle, if masked in;
  - visible on `readdata` at E0+2+`DEBOUNCE`, with address held.
- IRQMASK write at edge N: `irq` reflects the new mask after edge N.
- EDGECAPTURE clear at edge N: `irq` drops after edge N, unless a set happens on the same edge.
- Counter wrap is impossible: `cnt` resets at `DEBOUNCE-1` or on a match.

## Test plan
- Reset: assert `reset_n`=0 mid-operation, with `in_port`=8'hFF and IRQMASK=8'hFF. Required: `readdata`=0 and `irq`=0 immediately. After release, DATA reads 8'hFF and EDGECAPTURE reads 8'hFF after 2+`DEBOUNCE`+1 cycles.
- Latency: `DEBOUNCE`=4, `in_port` 8'h00→8'h05 sampled at E0, `address` held at 0. Required: `readdata`=32'h5 first after E0+6, exactly; 32'h0 before.
- Debounce: pulse bit 0 high for 3 cycles with `DEBOUNCE`=4. Required: DATA and EDGECAPTURE stay 0 and `irq` stays 0. A 4-cycle pulse sets both.
- Edge types: toggle bit 2 0→1→0, once per `EDGE_TYPE` setting. Required: EDGECAPTURE bit 2 = 1 only after the rising edge (0), only after the falling edge (1), and after each edge (2).
- IRQ and W1C: edges on bits 1 and 3, IRQMASK=8'h02. Required: `irq`=1. Write 32'h2 to address 3: EDGECAPTURE=8'h08 and `irq`=0. Write IRQMASK=8'h08: `irq`=1.
- Simultaneous set and clear: schedule bit 4's update event on the same edge as a write of 32'h10 to address 3. Required: bit 4 remains 1 and `irq` is asserted if masked.
